// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed active-low 7-segment scan driver with
// per-frame snapshot, inter-digit blanking, enable mask and leading-zero blanking.
module seg7_scan_driver #(
  parameter int NDIG      = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic [4*NDIG-1:0] iData,
  input  logic [NDIG-1:0]   iEnMask,
  input  logic              iLZS,
  output logic [NDIG-1:0]   oAN,
  output logic [6:0]        oDisplay,
  output logic              oFrame
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] data_q, data_d;
  logic [NDIG-1:0]   mask_q, mask_d;
  logic              lzs_q, lzs_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [6:0]        disp_q, disp_d;
  logic              frame_q, frame_d;

  logic              cap;
  logic              wrap;
  logic [NDIG-1:0]   lead;
  logic              run;
  logic [3:0]        dig;
  logic              dig_en;
  logic              dig_lead;
  logic              vis;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Slot timer, digit index and once-per-frame input snapshot
  always_comb begin
    wrap   = (cnt_q == CNT_LAST);
    cap    = (idx_q == '0) && (cnt_q == '0);
    cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    data_d  = cap ? iData   : data_q;
    mask_d  = cap ? iEnMask : mask_q;
    lzs_d   = cap ? iLZS    : lzs_q;
    frame_d = cap;
  end

  // Visibility and next anode/segment values for the current slot
  always_comb begin
    lead     = '0;
    run      = 1'b1;
    dig      = '0;
    dig_en   = 1'b0;
    dig_lead = 1'b0;
    an_d     = '1;
    disp_d   = 7'h7F;
    for (int k = NDIG - 1; k >= 0; k--) begin
      run     = run & (data_q[4*k +: 4] == 4'h0);
      lead[k] = run;
    end
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) begin
        dig      = data_q[4*k +: 4];
        dig_en   = mask_q[k];
        dig_lead = lead[k];
      end
    end
    vis = dig_en && !(lzs_q && (idx_q != '0) && dig_lead);
    if ((cnt_q >= CNT_BLNK) && vis) begin
      for (int k = 0; k < NDIG; k++) begin
        if (idx_q == IW'(k)) an_d[k] = 1'b0;
      end
      disp_d = decode(dig);
    end
  end

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (Rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      lzs_q   <= 1'b0;
      an_q    <= '1;
      disp_q  <= 7'h7F;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      lzs_q   <= lzs_d;
      an_q    <= an_d;
      disp_q  <= disp_d;
      frame_q <= frame_d;
    end
  end

  assign oAN      = an_q;
  assign oDisplay = disp_q;
  assign oFrame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed frame-by-frame checks of the scan driver
// with NDIG=4, SCAN_DIV=8, BLANK_CYC=2 (32-cycle frames).
module tb_seg7_scan_driver;

  logic        CLK = 1'b0;
  logic        Rst;
  logic [15:0] iData;
  logic [3:0]  iEnMask;
  logic        iLZS;
  logic [3:0]  oAN;
  logic [6:0]  oDisplay;
  logic        oFrame;

  int errs = 0;
  int chks = 0;

  seg7_scan_driver #(
    .NDIG(4), .SCAN_DIV(8), .BLANK_CYC(2)
  ) dut (
    .CLK(CLK), .Rst(Rst), .iData(iData), .iEnMask(iEnMask),
    .iLZS(iLZS), .oAN(oAN), .oDisplay(oDisplay), .oFrame(oFrame)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one 32-cycle frame starting just before the capture edge.
  // an_e/dp_e hold expected lit values per digit (digit 3 in the MSBs).
  task automatic run_frame(input string tag, input logic [15:0] an_e,
                           input logic [27:0] dp_e, input int chg_at,
                           input logic [15:0] chg_val);
    int i, c;
    for (int p = 0; p < 32; p++) begin
      step();
      i = p / 8;
      c = p % 8;
      if (c < 2) begin
        check({tag, "_an_blank"}, 32'(oAN), 32'hF);
        check({tag, "_seg_blank"}, 32'(oDisplay), 32'h7F);
      end else begin
        check({tag, "_an"}, 32'(oAN), 32'(an_e[4*i +: 4]));
        check({tag, "_seg"}, 32'(oDisplay), 32'(dp_e[7*i +: 7]));
      end
      check({tag, "_frame"}, 32'(oFrame), 32'(p == 0));
      check({tag, "_onehot"}, 32'($countones(~oAN) <= 1), 32'd1);
      if (p == chg_at) iData = chg_val;
    end
  endtask

  initial begin
    Rst = 1'b1;
    iData = 16'h1234;
    iEnMask = 4'hF;
    iLZS = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_an", 32'(oAN), 32'hF);
      check("rst_seg", 32'(oDisplay), 32'h7F);
      check("rst_frame", 32'(oFrame), 32'd0);
    end
    Rst = 1'b0;

    run_frame("d1234", {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h79, 7'h24, 7'h30, 7'h19}, -1, 16'h0);
    run_frame("d1234b", {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h79, 7'h24, 7'h30, 7'h19}, -1, 16'h0);

    iData = 16'h0050;
    iLZS = 1'b1;
    run_frame("lzs50", {4'hF, 4'hF, 4'hD, 4'hE},
              {7'h7F, 7'h7F, 7'h12, 7'h40}, -1, 16'h0);
    iData = 16'h0000;
    run_frame("lzs0", {4'hF, 4'hF, 4'hF, 4'hE},
              {7'h7F, 7'h7F, 7'h7F, 7'h40}, -1, 16'h0);

    iData = 16'h1234;
    iLZS = 1'b0;
    run_frame("tear", {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h79, 7'h24, 7'h30, 7'h19}, 16, 16'hABCD);
    run_frame("dABCD", {4'h7, 4'hB, 4'hD, 4'hE},
              {7'h08, 7'h03, 7'h46, 7'h21}, -1, 16'h0);

    iData = 16'h8888;
    iEnMask = 4'b0101;
    run_frame("mask", {4'hF, 4'hB, 4'hF, 4'hE},
              {7'h7F, 7'h00, 7'h7F, 7'h00}, -1, 16'h0);

    iData = 16'h00A7;
    iEnMask = 4'hF;
    for (int p = 0; p < 21; p++) step();
    Rst = 1'b1;
    step();
    check("mid_rst_an", 32'(oAN), 32'hF);
    check("mid_rst_seg", 32'(oDisplay), 32'h7F);
    check("mid_rst_frame", 32'(oFrame), 32'd0);
    Rst = 1'b0;
    step();
    check("restart_frame", 32'(oFrame), 32'd1);
    check("restart_an1", 32'(oAN), 32'hF);
    step();
    check("restart_an2", 32'(oAN), 32'hF);
    check("restart_frame2", 32'(oFrame), 32'd0);
    step();
    check("restart_an3", 32'(oAN), 32'hE);
    check("restart_seg3", 32'(oDisplay), 32'h78);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
